weight_loader: RTL and testbench
================================

# weight_loader

Streams one 3-channel 3x3 depthwise kernel set (28 words: 27 weights plus one pad) into the dual-port weight BRAM that the convolution layer later reads. Words 0..13 go to port A at addresses 0..13, and words 14..27 go to port B at addresses 14..27. The block buffers the first half internally. During the second half it writes one word on each port in the same cycle, so the BRAM contents match the layout the layer's read sequencer expects.

## Interface
- bit_depth, 16, weight word width
- n_half, 14, words per BRAM port
- addr_width, 5, BRAM address width
- park_addr, 31, address driven on both ports when not writing
- clk  in  1  sole clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse that begins a load session
- abort  in  1  cancels an active session
- in_data  in  bit_depth  incoming weight word
- in_valid  in  1  in_data is valid
- in_ready  out  1  block accepts a word this cycle
- wren_a, wren_b  out  1 each  BRAM write enables
- addr_a, addr_b  out  addr_width each  BRAM addresses
- data_a, data_b  out  bit_depth each  BRAM write data
- busy  out  1  session active
- done  out  1  single-cycle pulse marking load complete

## Operation
- States:
  - IDLE: in_ready=0.
  - COLLECT: in_ready=1.
  - PAIR: in_ready=1.
  - FINISH: in_ready=0.
- Counter cnt (5 bits) counts accepted words, range 0..27.
- Transfer occurs when in_valid && in_ready.
- IDLE: start -> COLLECT, cnt=0. in_valid is ignored.
- COLLECT: each transfer stores in_data into buffer[cnt] and increments cnt. No BRAM writes occur. The transfer with cnt==13 moves the state to PAIR.
- PAIR: each transfer with word index k (14..27) issues one dual write:
  - port A: addr k-14, data buffer[k-14].
  - port B: addr k, data in_data.
  - The transfer with k==27 moves the state to FINISH.
- FINISH: lasts 1 cycle, then returns to IDLE.
- Write outputs are registered:
  - wren_a and wren_b are high for exactly 1 cycle, the cycle after each PAIR transfer.
  - Otherwise wren=0, addr=park_addr, data=0.
- abort in COLLECT or PAIR -> IDLE next cycle.
  - Buffered words are discarded and no done is issued.
  - A write already registered from the abort cycle's transfer is suppressed.
- abort and start in the same cycle: abort wins; the state stays or goes to IDLE.
- start while busy is ignored. abort in IDLE or FINISH is ignored.
- Buffer contents are not cleared on reset. Correctness never depends on stale buffer data.

## Timing
- Reset values:
  - in_ready=0, busy=0, done=0.
  - wren_a=wren_b=0, addr_a=addr_b=park_addr, data_a=data_b=0.
  - State IDLE, cnt=0.
- in_ready and busy are decoded from the registered state; there is no combinational path from in_valid.
- busy is high from the cycle after start through FINISH.
- Latency: for a PAIR transfer at cycle t, the dual write appears at t+1.
- If the final transfer is at cycle t:
  - done pulses at t+1, coincident with the last write.
  - FINISH occupies t+1; IDLE is entered at t+2.
- Back-to-back input: 28 transfer cycles, then done on the next cycle.
- in_valid gaps: writes occur only on cycles following transfers, and addresses park between them.
- RESET asserted mid-session: all outputs take their reset values immediately, without waiting for clk.

## Configuration
- WEIGHT_LOADER_CHECKSUM_EN defined:
  - Adds output checksum (bit_depth): the modulo-2^bit_depth sum of all 28 accepted words.
  - checksum is valid while done is high and holds until the next start. It clears to 0 on start and on reset.
- WEIGHT_LOADER_CHECKSUM_EN undefined: no checksum port and no adder logic.

## Structure
- Package weight_loader_pkg holds:
  - State enum: IDLE, COLLECT, PAIR, FINISH.
  - Constants N_HALF=14, N_TOTAL=28, PARK_ADDR=31.
- Sub-module weight_half_buffer: n_half x bit_depth register file with one write index and one read index, used for port A data.

## Test plan
- Reset: RESET=1 at any time -> wren_a=wren_b=0, addr_a=addr_b=31, in_ready=0, done=0, busy=0.
- start, then words 100..127 back-to-back:
  - No wren during the first 14 transfers.
  - Then 14 dual writes: A(0,100)..A(13,113) with B(14,114)..B(27,127).
  - done high for 1 cycle with the final write.
- Same stream with in_valid alternating 1/0 -> identical write pairs; wren only on the cycles after transfers; addr=31 between writes.
- abort after 20 transfers:
  - Exactly 6 dual writes (A 0..5, B 14..19), no done, busy low the next cycle.
  - A new start with 28 words writes A0 from the new data.
- RESET asserted during PAIR after 17 transfers -> outputs reset immediately. A post-reset session behaves as in the back-to-back case.
- WEIGHT_LOADER_CHECKSUM_EN defined, 28 words of 16'hFFFF -> checksum=16'hFFE4 while done is high.

Source files
------------

// File: rtl/weight_loader_pkg.sv
// Shared types and constants for the weight_loader kernel-set streamer.
// Optional checksum output is enabled by defining WEIGHT_LOADER_CHECKSUM_EN.
package weight_loader_pkg;

  localparam int unsigned N_HALF    = 14;
  localparam int unsigned N_TOTAL   = 28;
  localparam int unsigned PARK_ADDR = 31;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    PAIR,
    FINISH
  } wl_state_e;

  // Index into the half buffer for the port-A word that pairs with word k.
  function automatic int unsigned pair_index(input int unsigned k);
    return k - N_HALF;
  endfunction

endpackage

// File: rtl/weight_half_buffer.sv
// Register file holding the first half of a kernel set until it is paired with
// the second half. Contents are intentionally not reset.
module weight_half_buffer #(
  parameter int unsigned Depth = 14,
  parameter int unsigned Width = 16
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic [$clog2(Depth)-1:0] raddr_i,
  output logic [Width-1:0]         rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/weight_loader.sv
// Streams a 28-word depthwise kernel set into a dual-port weight BRAM, pairing
// words k-14 (port A) and k (port B). Define WEIGHT_LOADER_CHECKSUM_EN for checksum.
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int unsigned bit_depth  = 16,
  parameter int unsigned n_half     = N_HALF,
  parameter int unsigned addr_width = 5,
  parameter int unsigned park_addr  = PARK_ADDR
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic                  start,
  input  logic                  abort,
  input  logic [bit_depth-1:0]  in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wren_a,
  output logic                  wren_b,
  output logic [addr_width-1:0] addr_a,
  output logic [addr_width-1:0] addr_b,
  output logic [bit_depth-1:0]  data_a,
  output logic [bit_depth-1:0]  data_b,
  output logic                  busy,
  output logic                  done
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  ,
  output logic [bit_depth-1:0]  checksum
`endif
);

  localparam int unsigned IdxW = $clog2(n_half);
  localparam logic [addr_width-1:0] LastCollect = addr_width'(n_half - 1);
  localparam logic [addr_width-1:0] LastWord    = addr_width'(2 * n_half - 1);
  localparam logic [addr_width-1:0] HalfOffset  = addr_width'(pair_index(n_half) + n_half);
  localparam logic [addr_width-1:0] ParkAddr    = addr_width'(park_addr);

  wl_state_e             state_q, state_d;
  logic [addr_width-1:0] cnt_q, cnt_d;
  logic                  xfer;
  logic                  sess_start;
  logic                  buf_we;
  logic                  pair_wr;
  logic [IdxW-1:0]       buf_waddr;
  logic [IdxW-1:0]       buf_raddr;
  logic [bit_depth-1:0]  buf_rdata;

  logic                  wren_q, wren_d;
  logic [addr_width-1:0] addr_a_q, addr_a_d;
  logic [addr_width-1:0] addr_b_q, addr_b_d;
  logic [bit_depth-1:0]  data_a_q, data_a_d;
  logic [bit_depth-1:0]  data_b_q, data_b_d;

  // Handshake status comes only from the registered state.
  assign in_ready = (state_q == COLLECT) || (state_q == PAIR);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FINISH);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sess_start = 1'b0;
    buf_we     = 1'b0;
    pair_wr    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          sess_start = 1'b1;
          state_d    = COLLECT;
          cnt_d      = '0;
        end
      end
      COLLECT: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (xfer) begin
          buf_we = 1'b1;
          cnt_d  = cnt_q + addr_width'(1);
          if (cnt_q == LastCollect) begin
            state_d = PAIR;
          end
        end
      end
      PAIR: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (xfer) begin
          pair_wr = 1'b1;
          if (cnt_q == LastWord) begin
            state_d = FINISH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + addr_width'(1);
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign buf_waddr = IdxW'(cnt_q);
  assign buf_raddr = IdxW'(cnt_q - HalfOffset);

  weight_half_buffer #(
    .Depth(n_half),
    .Width(bit_depth)
  ) u_half_buffer (
    .clk_i  (clk),
    .we_i   (buf_we),
    .waddr_i(buf_waddr),
    .wdata_i(in_data),
    .raddr_i(buf_raddr),
    .rdata_o(buf_rdata)
  );

  // Both ports park on an unused address whenever no pair is being written.
  always_comb begin
    wren_d   = 1'b0;
    addr_a_d = ParkAddr;
    addr_b_d = ParkAddr;
    data_a_d = '0;
    data_b_d = '0;
    if (pair_wr) begin
      wren_d   = 1'b1;
      addr_a_d = cnt_q - HalfOffset;
      addr_b_d = cnt_q;
      data_a_d = buf_rdata;
      data_b_d = in_data;
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      wren_q   <= 1'b0;
      addr_a_q <= ParkAddr;
      addr_b_q <= ParkAddr;
      data_a_q <= '0;
      data_b_q <= '0;
    end else begin
      wren_q   <= wren_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
    end
  end

  assign wren_a = wren_q;
  assign wren_b = wren_q;
  assign addr_a = addr_a_q;
  assign addr_b = addr_b_q;
  assign data_a = data_a_q;
  assign data_b = data_b_q;

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [bit_depth-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (sess_start) begin
      csum_d = '0;
    end else if (buf_we || pair_wr) begin
      csum_d = csum_q + in_data;
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_weight_loader.sv
// Self-checking bench for weight_loader: queue-based session model compared every
// cycle, plus literal write-log checks. Covers WEIGHT_LOADER_CHECKSUM_EN when defined.
module tb_weight_loader;

  logic        clk = 1'b0;
  logic        RESET = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready, wren_a, wren_b, busy, done;
  logic [4:0]  addr_a, addr_b;
  logic [15:0] data_a, data_b;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [15:0] checksum;
  logic [15:0] csum_at_done = '0;
`endif

  always #5 clk = ~clk;

  weight_loader dut (
    .clk     (clk),
    .RESET   (RESET),
    .start   (start),
    .abort   (abort),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .wren_a  (wren_a),
    .wren_b  (wren_b),
    .addr_a  (addr_a),
    .addr_b  (addr_b),
    .data_a  (data_a),
    .data_b  (data_b),
    .busy    (busy),
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    .checksum(checksum),
`endif
    .done    (done)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;
  logic [42:0] wlog[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [42:0] wr(input logic d, input int aa, input int da, input int ab,
                                     input int db);
    return {d, 5'(aa), 16'(da), 5'(ab), 16'(db)};
  endfunction

  // Session model: a session collects 28 words; word k >= 14 pairs with word k-14.
  bit          m_active = 1'b0;
  bit          m_fin = 1'b0;
  logic [15:0] m_words[$];
  logic [15:0] m_csum = '0;
  logic        e_wren = 1'b0, e_done = 1'b0, e_busy = 1'b0, e_in_ready = 1'b0;
  logic [4:0]  e_addr_a = 5'd31, e_addr_b = 5'd31;
  logic [15:0] e_data_a = '0, e_data_b = '0;

  task automatic model_step();
    int k;
    e_wren = 1'b0; e_done = 1'b0;
    e_addr_a = 5'd31; e_addr_b = 5'd31; e_data_a = '0; e_data_b = '0;
    if (RESET) begin
      m_active = 1'b0; m_fin = 1'b0; m_words.delete(); m_csum = '0;
    end else if (m_fin) begin
      m_fin = 1'b0;
    end else if (!m_active) begin
      if (start && !abort) begin
        m_active = 1'b1; m_words.delete(); m_csum = '0;
      end
    end else if (abort) begin
      m_active = 1'b0; m_words.delete();
    end else if (in_valid) begin
      m_words.push_back(in_data);
      m_csum = m_csum + in_data;
      k = m_words.size() - 1;
      if (k >= 14) begin
        e_wren = 1'b1;
        e_addr_a = 5'(k - 14); e_data_a = m_words[k-14];
        e_addr_b = 5'(k);      e_data_b = in_data;
      end
      if (m_words.size() == 28) begin
        m_active = 1'b0; m_fin = 1'b1; e_done = 1'b1;
      end
    end
    e_busy = m_active || m_fin;
    e_in_ready = m_active;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (RESET) begin
      chk("rst_wren_a", wren_a, 0); chk("rst_wren_b", wren_b, 0);
      chk("rst_addr_a", addr_a, 31); chk("rst_addr_b", addr_b, 31);
      chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_in_ready", in_ready, 0);
    end else begin
      chk("in_ready", in_ready, e_in_ready);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("wren_a", wren_a, e_wren);
      chk("wren_b", wren_b, e_wren);
      chk("addr_a", addr_a, e_addr_a);
      chk("addr_b", addr_b, e_addr_b);
      chk("data_a", data_a, e_data_a);
      chk("data_b", data_b, e_data_b);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      if (e_done) chk("checksum", checksum, m_csum);
`endif
    end
    if (wren_a) wlog.push_back({done, addr_a, data_a, addr_b, data_b});
    if (done) begin
      n_done++;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      csum_at_done = checksum;
`endif
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1; abort = 1'b0; in_valid = 1'b0;
  endtask

  task automatic send_words(input int base, input int step, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; in_data = 16'(base + i * step);
      if (gaps) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
    end
  endtask

  initial begin
    int done_before;
    #1 RESET = 1'b1;
    #1;
    chk("lit_reset_wren", wren_a, 0); chk("lit_reset_addr_b", addr_b, 31);
    chk("lit_reset_busy", busy, 0);
    repeat (2) @(negedge clk);
    #1 RESET = 1'b0;

    // Idle: in_valid, abort and start+abort must all be ignored.
    @(negedge clk); in_valid = 1'b1; in_data = 16'd5; abort = 1'b1;
    @(negedge clk); start = 1'b1;
    idle(2);

    // Back-to-back session.
    wlog.delete(); done_before = n_done;
    do_start(); send_words(100, 1, 28, 1'b0); idle(4);
    chk("b2b_nwrites", wlog.size(), 14);
    chk("b2b_first", wlog[0], wr(0, 0, 100, 14, 114));
    chk("b2b_w12", wlog[12], wr(0, 12, 112, 26, 126));
    chk("b2b_last", wlog[13], wr(1, 13, 113, 27, 127));
    chk("b2b_done", n_done - done_before, 1);

    // Same stream with in_valid alternating.
    wlog.delete(); done_before = n_done;
    do_start(); send_words(100, 1, 28, 1'b1); idle(4);
    chk("gap_nwrites", wlog.size(), 14);
    chk("gap_w5", wlog[5], wr(0, 5, 105, 19, 119));
    chk("gap_last", wlog[13], wr(1, 13, 113, 27, 127));
    chk("gap_done", n_done - done_before, 1);

    // Abort after 20 transfers, then a fresh session.
    wlog.delete(); done_before = n_done;
    do_start(); send_words(200, 1, 20, 1'b0);
    @(negedge clk); in_valid = 1'b0; abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    #1 chk("abort_busy", busy, 0);
    idle(2);
    chk("abort_nwrites", wlog.size(), 6);
    chk("abort_first", wlog[0], wr(0, 0, 200, 14, 214));
    chk("abort_w5", wlog[5], wr(0, 5, 205, 19, 219));
    chk("abort_nodone", n_done - done_before, 0);
    wlog.delete();
    do_start(); send_words(300, 1, 28, 1'b0); idle(4);
    chk("post_abort_first", wlog[0], wr(0, 0, 300, 14, 314));
    chk("post_abort_n", wlog.size(), 14);

    // Asynchronous reset in PAIR after 17 transfers.
    wlog.delete(); done_before = n_done;
    do_start(); send_words(100, 1, 17, 1'b0);
    @(posedge clk); #2;
    in_valid = 1'b0;
    chk("pre_rst_write", {wren_a, addr_a, data_a, addr_b, data_b},
        {1'b1, 5'd2, 16'd102, 5'd16, 16'd116});
    RESET = 1'b1;
    #1;
    chk("async_wren_a", wren_a, 0); chk("async_wren_b", wren_b, 0);
    chk("async_addr_a", addr_a, 31); chk("async_addr_b", addr_b, 31);
    chk("async_data_a", data_a, 0); chk("async_busy", busy, 0);
    chk("async_in_ready", in_ready, 0); chk("async_done", done, 0);
    repeat (2) @(negedge clk);
    #1 RESET = 1'b0;
    wlog.delete();
    do_start(); send_words(100, 1, 28, 1'b0); idle(4);
    chk("post_rst_n", wlog.size(), 14);
    chk("post_rst_first", wlog[0], wr(0, 0, 100, 14, 114));
    chk("post_rst_last", wlog[13], wr(1, 13, 113, 27, 127));
    chk("post_rst_done", n_done - done_before, 1);

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    do_start(); send_words(16'hFFFF, 0, 28, 1'b0); idle(4);
    chk("checksum_lit", csum_at_done, 16'hFFE4);
`endif

    idle(2);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
